median_sort_sequencer: RTL
==========================

# median_sort_sequencer

Time-multiplexed sorter for the median filter: accepts one N-sample window, sorts it in place by running an odd-even transposition schedule through a single internal `comparator` instance (one compare-exchange per clock), then presents the sorted window and its median. It sits between the window-forming line buffer and the output pixel stage. It trades throughput for area against the fully unrolled sorting network.

## Interface
- `DATA_WIDTH`, 8, unsigned sample width; passed to the internal `comparator`.
- `N`, 9, window size; must be odd and ≥ 3. Elaboration fails otherwise.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_valid`  in  1  `in_data` holds a window.
- `in_ready`  out  1  sequencer can accept a window this cycle.
- `in_data`  in  N*DATA_WIDTH  window; element k is at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- `out_valid`  out  1  sorted result is available.
- `out_ready`  in  1  downstream consumes the result.
- `out_sorted`  out  N*DATA_WIDTH  sorted window, ascending; element 0 is the smallest. Same packing as `in_data`.
- `out_median`  out  DATA_WIDTH  element (N-1)/2 of `out_sorted`.
- `busy`  out  1  high in SORT.

## Operation
- Internal storage is a working register array `w[0..N-1]`. `out_sorted` is driven directly from `w`. Its value is don't-care whenever `out_valid` is 0.
- States:
  - IDLE: `in_ready`=1. On `in_valid`, load `w` from `in_data`, clear the counters and go to SORT.
  - SORT: one compare-exchange per cycle.
  - DONE: `out_valid`=1, `w` frozen.
- `in_ready` = (IDLE) or (DONE and `out_ready`). This is combinational from state and `out_ready`.
- DONE transitions:
  - `out_ready` with `in_valid`: load the new window and go to SORT (back-to-back).
  - `out_ready` alone: go to IDLE.
  - Otherwise hold DONE.
- Schedule:
  - Phase counter p runs 0..N-1. Pair counter j runs 0..(N-3)/2.
  - Pair index i = 2j + (p mod 2).
  - Each SORT cycle: the comparator sees {w[i], w[i+1]}; w[i] is updated with `smaller` and w[i+1] with `greater`.
  - j increments each cycle. On wrap, j resets to 0 and p increments.
  - After the last pair of phase N-1, go to DONE.
- The comparator swaps only when w[i] > w[i+1] (unsigned). Equal values are never swapped.
- Pair count: (N-1)/2 per phase, N phases, so C = N(N-1)/2 compare cycles. For N=9, C=36.
- Reset asserted at any time, including mid-SORT or in DONE, behaves as follows:
  - The in-flight window is discarded.
  - State goes to IDLE, `w` to 0, and the counters to 0.
  - No `out_valid` pulse is produced for the discarded window.
- `in_valid` during SORT is ignored (`in_ready`=0). The upstream must hold its data.

## Timing
- Reset values:
  - state IDLE, so `in_ready`=1 while `rst_n` is low.
  - `out_valid`=0, `busy`=0.
  - `out_sorted`=0, `out_median`=0.
- Cycle numbering:
  - Accept at edge t (`in_valid` & `in_ready` sampled high).
  - Compare-exchanges occur at edges t+1 … t+C.
  - `out_valid` is high from just after edge t+C.
- Latency from accept edge to `out_valid` is C cycles (36 for N=9).
- Sustained throughput with `out_ready` tied high is one window per C+1 cycles.
- In DONE, `out_sorted`/`out_median` stay stable until the handshake edge, for any length of `out_ready` low.
- `busy` is high exactly for the C cycles of SORT.

## Test plan
- Reversed input, N=9, DW=8: in_data elements 9,8,…,1 → after 36 cycles `out_valid`=1, out_sorted=1..9 ascending, `out_median`=5.
- All-equal and extremes:
  - nine copies of 0x7F → out_sorted all 0x7F, median 0x7F.
  - {255,0,255,0,255,0,255,0,255} → four 0 then five 255, median 255.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` → outputs and `out_valid` remain stable, `in_ready`=0. Release `out_ready` → one transfer, then IDLE.
- Back-to-back: `in_valid` and `out_ready` held high with random windows → each result is correct and out_valid rises every 37 cycles. No window is lost or duplicated.
- Mid-sort reset: assert `rst_n`=0 at cycle 10 of SORT, then release → `out_valid` never rises for that window. The next window sorts correctly.
- Random regression: 10k random windows checked against a software sort model (median and full order), with random `in_valid`/`out_ready` gaps. Also check the N=3 and N=5 parameter builds.

Source files
------------

// File: rtl/median_sort_sequencer_if.sv
// ---------------------------------------------------------------------------
// median_sort_sequencer_if
//   Handshake bundle between the window-forming line buffer, the sorter and
//   the output pixel stage.
//
//   in_valid   upstream -> sorter  : in_data holds a window
//   in_ready   sorter   -> upstream: sorter can accept a window this cycle
//   in_data    upstream -> sorter  : N packed samples, element k at
//                                    [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   out_valid  sorter   -> down    : sorted result available
//   out_ready  down     -> sorter  : downstream consumes the result
//   out_sorted sorter   -> down    : ascending window, same packing
//   out_median sorter   -> down    : element (N-1)/2 of out_sorted
//
//   master: the environment (upstream + downstream); slave: the sorter.
// ---------------------------------------------------------------------------
interface median_sort_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 9
);
    logic                      in_valid;
    logic                      in_ready;
    logic [N*DATA_WIDTH-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [N*DATA_WIDTH-1:0]   out_sorted;
    logic [DATA_WIDTH-1:0]     out_median;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sorted, out_median
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sorted, out_median
    );
endinterface

// File: rtl/median_sort_sequencer.sv
// ---------------------------------------------------------------------------
// median_sort_sequencer
//   Time-multiplexed sorter for the median filter. One window of N samples is
//   loaded into a working array and sorted in place by an odd-even
//   transposition schedule that drives a single comparator, one
//   compare-exchange per clock (N*(N-1)/2 cycles per window). The sorted
//   window and its median are then held until downstream takes them.
//
//   Ports:
//     clk    : sole clock, rising edge
//     rst_n  : asynchronous, active-low reset
//     bus    : median_sort_sequencer_if.slave (window in / result out)
//     busy   : high while sorting
// ---------------------------------------------------------------------------

// Unsigned compare-exchange element: never swaps equal values.
module comparator #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_smaller,
    output logic [DATA_WIDTH-1:0] o_greater
);
    logic w_swap;

    assign w_swap    = (i_a > i_b);
    assign o_smaller = w_swap ? i_b : i_a;
    assign o_greater = w_swap ? i_a : i_b;
endmodule

module median_sort_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    median_sort_sequencer_if.slave   bus,
    output logic                     busy
);
    // Counter geometry. j needs at least one bit even when N=3 (single pair).
    localparam int J_MAX = (N - 3) / 2;
    localparam int PW    = $clog2(N);
    localparam int JW    = (J_MAX > 0) ? $clog2(J_MAX + 1) : 1;
    localparam int IW    = $clog2(N);

    localparam logic [PW-1:0] P_LAST = PW'(N - 1);
    localparam logic [JW-1:0] J_LAST = JW'(J_MAX);

    if (N < 3 || (N % 2) == 0) begin : g_bad_n
        $error("median_sort_sequencer: N must be odd and >= 3");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SORT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_win [N];
    logic [PW-1:0]         r_p;
    logic [JW-1:0]         r_j;

    logic                  w_load;
    logic                  w_last_pair;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_idx_hi;
    logic [DATA_WIDTH-1:0] w_smaller;
    logic [DATA_WIDTH-1:0] w_greater;

    // Pair index i = 2j + (p mod 2): even phases start at 0, odd at 1.
    assign w_idx       = IW'({r_j, 1'b0}) + IW'(r_p[0]);
    assign w_idx_hi    = w_idx + IW'(1);
    assign w_last_pair = (r_p == P_LAST) && (r_j == J_LAST);

    comparator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_comparator (
        .i_a       (r_win[w_idx]),
        .i_b       (r_win[w_idx_hi]),
        .o_smaller (w_smaller),
        .o_greater (w_greater)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, regardless of block order.
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        bus.in_ready = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SORT;
                end
            end
            S_SORT: begin
                if (w_last_pair) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Releasing the result and accepting the next window share
                // one edge, giving back-to-back throughput of one per C+1.
                bus.in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_SORT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Working array and schedule counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the working array is reset explicitly because the reset
            // output value of out_sorted is defined as all zeros; it is a
            // small register file, not a RAM, so this costs nothing unusual.
            for (int k = 0; k < N; k++) begin
                r_win[k] <= '0;
            end
            r_p <= '0;
            r_j <= '0;
        end else if (w_load) begin
            for (int k = 0; k < N; k++) begin
                r_win[k] <= bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            r_p <= '0;
            r_j <= '0;
        end else if (r_state == S_SORT) begin
            r_win[w_idx]    <= w_smaller;
            r_win[w_idx_hi] <= w_greater;
            if (r_j == J_LAST) begin
                r_j <= '0;
                r_p <= r_p + PW'(1);
            end else begin
                r_j <= r_j + JW'(1);
            end
        end
    end

    // Result is read straight out of the working array.
    for (genvar k = 0; k < N; k++) begin : g_pack
        assign bus.out_sorted[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
    end

    assign bus.out_median = r_win[(N-1)/2];
    assign bus.out_valid  = (r_state == S_DONE);
    assign busy           = (r_state == S_SORT);
endmodule
